// File: rtl/mac_operand_sequencer_pkg.sv
// Shared constants, FSM encoding and command payload for the MAC operand sequencer.
package mac_operand_sequencer_pkg;

    localparam int unsigned I_W    = 32;          // signed operand width
    localparam int unsigned ADDR_W = 10;          // buffer address width
    localparam int unsigned LEN_W  = 10;          // vector length width
    localparam int unsigned RES_W  = 2 * I_W + 2; // MAC result width

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CLEAR   = 3'd1;
    localparam state_t ST_STREAM  = 3'd2;
    localparam state_t ST_DRAIN   = 3'd3;
    localparam state_t ST_LOAD    = 3'd4;
    localparam state_t ST_CAPTURE = 3'd5;
    localparam state_t ST_HOLD    = 3'd6;

    // One dot-product command, latched when start is accepted.
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] act_base;
        logic [ADDR_W-1:0] wgt_base;
    } seq_cmd_t;

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Bundle of command, buffer read, MAC and result signals of one lane.
// master: the sequencer. slave: buffers, MAC and layer controller.
interface mac_operand_sequencer_if;
    import mac_operand_sequencer_pkg::*;

    logic                     start;
    logic [LEN_W-1:0]         vec_len;
    logic [ADDR_W-1:0]        act_base;
    logic [ADDR_W-1:0]        wgt_base;
    logic                     act_rd_en;
    logic [ADDR_W-1:0]        act_addr;
    logic signed [I_W-1:0]    act_data;
    logic                     wgt_rd_en;
    logic [ADDR_W-1:0]        wgt_addr;
    logic signed [I_W-1:0]    wgt_data;
    logic                     mac_clr;
    logic                     mac_en;
    logic signed [I_W-1:0]    mac_A;
    logic signed [I_W-1:0]    mac_B;
    logic                     mac_en_out;
    logic signed [RES_W-1:0]  mac_Y;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [RES_W-1:0]  res_data;
    logic                     busy;

    modport master (
        input  start, vec_len, act_base, wgt_base,
        input  act_data, wgt_data, mac_Y, res_ready,
        output act_rd_en, act_addr, wgt_rd_en, wgt_addr,
        output mac_clr, mac_en, mac_A, mac_B, mac_en_out,
        output res_valid, res_data, busy
    );

    modport slave (
        output start, vec_len, act_base, wgt_base,
        output act_data, wgt_data, mac_Y, res_ready,
        input  act_rd_en, act_addr, wgt_rd_en, wgt_addr,
        input  mac_clr, mac_en, mac_A, mac_B, mac_en_out,
        input  res_valid, res_data, busy
    );

endinterface

// File: rtl/mac_operand_sequencer_seq_addr_gen.sv
// Address generator: latches the command, counts issued element index k,
// produces registered base+k addresses (wrapping) and flags the final one.
// Ports: clk, rst (async active-low), load (latch cmd), cmd, issue (emit next
// address), act_addr/wgt_addr (registered, zero when not issuing), last
// (registered address is k=N-1), empty (latched N is zero).
module mac_operand_sequencer_seq_addr_gen
    import mac_operand_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  seq_cmd_t          cmd,
    input  logic              issue,
    output logic [ADDR_W-1:0] act_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic              last,
    output logic              empty
);

    seq_cmd_t         cmd_q;
    logic [LEN_W-1:0] cnt;

    assign empty = (cmd_q.len == '0);

    // Command latch, element counter and registered addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q    <= '0;
            cnt      <= '0;
            act_addr <= '0;
            wgt_addr <= '0;
            last     <= 1'b0;
        end else begin
            if (load) begin
                cmd_q <= cmd;
                cnt   <= '0;
            end
            if (issue) begin
                act_addr <= cmd_q.act_base + ADDR_W'(cnt);
                wgt_addr <= cmd_q.wgt_base + ADDR_W'(cnt);
                cnt      <= cnt + LEN_W'(1);
                last     <= (cnt == cmd_q.len - LEN_W'(1));
            end else begin
                act_addr <= '0;
                wgt_addr <= '0;
                last     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Initiator side of the MAC: streams one length-N dot product from the
// activation/weight buffers through the MAC and offers the result on a
// valid/ready port.
// Ports: clk, rst (async active-low), bus (master modport): command
// start/vec_len/act_base/wgt_base, buffer read ports, MAC controls
// mac_clr/mac_en/mac_en_out with operands mac_A/mac_B (pass-through of read
// data), mac_Y result input, res_valid/res_ready/res_data, busy.
module mac_operand_sequencer
    import mac_operand_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    mac_operand_sequencer_if.master bus
);

    state_t   state;
    state_t   next_state;
    seq_cmd_t cmd;
    logic     load;
    logic     issue;
    logic     last;
    logic     empty;
    logic     rd_en_d;
    logic     clr_d;
    logic     en_out_d;
    logic     busy_d;
    logic     res_valid_d;
    logic     res_load;
    logic     rd_en_q;

    assign cmd = '{len: bus.vec_len, act_base: bus.act_base, wgt_base: bus.wgt_base};

    // Read data lines up with the delayed mac_en, so operands pass straight through.
    assign bus.mac_A = bus.act_data;
    assign bus.mac_B = bus.wgt_data;

    mac_operand_sequencer_seq_addr_gen u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .cmd      (cmd),
        .issue    (issue),
        .act_addr (bus.act_addr),
        .wgt_addr (bus.wgt_addr),
        .last     (last),
        .empty    (empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (bus.start) next_state = ST_CLEAR;
            ST_CLEAR:   next_state = empty ? ST_LOAD : ST_STREAM;
            ST_STREAM:  if (last) next_state = ST_DRAIN;
            ST_DRAIN:   next_state = ST_LOAD;
            ST_LOAD:    next_state = ST_CAPTURE;
            ST_CAPTURE: next_state = ST_HOLD;
            ST_HOLD:    if (bus.res_ready) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Output decode from the next state so registered outputs track the state.
    always_comb begin
        load        = 1'b0;
        issue       = 1'b0;
        rd_en_d     = 1'b0;
        clr_d       = 1'b0;
        en_out_d    = 1'b0;
        busy_d      = 1'b0;
        res_valid_d = 1'b0;
        res_load    = 1'b0;
        load        = (state == ST_IDLE) && bus.start;
        rd_en_d     = (next_state == ST_STREAM);
        issue       = rd_en_d;
        clr_d       = (next_state == ST_CLEAR);
        en_out_d    = (next_state == ST_LOAD);
        busy_d      = (next_state != ST_IDLE);
        res_valid_d = (next_state == ST_HOLD);
        res_load    = (state == ST_CAPTURE);
    end

    // Output registers; mac_en is the read strobe delayed to meet the returning data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q        <= 1'b0;
            bus.act_rd_en  <= 1'b0;
            bus.wgt_rd_en  <= 1'b0;
            bus.mac_clr    <= 1'b0;
            bus.mac_en     <= 1'b0;
            bus.mac_en_out <= 1'b0;
            bus.busy       <= 1'b0;
            bus.res_valid  <= 1'b0;
            bus.res_data   <= '0;
        end else begin
            rd_en_q        <= rd_en_d;
            bus.act_rd_en  <= rd_en_d;
            bus.wgt_rd_en  <= rd_en_d;
            bus.mac_clr    <= clr_d;
            bus.mac_en     <= rd_en_q;
            bus.mac_en_out <= en_out_d;
            bus.busy       <= busy_d;
            bus.res_valid  <= res_valid_d;
            if (res_load) begin
                bus.res_data <= bus.mac_Y;
            end
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: behavioural buffers and MAC around the DUT,
// directed and random dot products checked against a reference sum.
module tb_mac_operand_sequencer;
    import mac_operand_sequencer_pkg::*;

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic signed [I_W-1:0]   act_mem [DEPTH];
    logic signed [I_W-1:0]   wgt_mem [DEPTH];
    logic signed [RES_W-1:0] acc;
    logic signed [2*I_W-1:0] prod;

    int en_cnt, clr_cnt, eo_cnt, ohv_cnt, busy_low;
    int act_q [$];
    int wgt_q [$];

    mac_operand_sequencer_if bus ();

    mac_operand_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffers with one-cycle read latency.
    always @(posedge clk) begin
        bus.act_data <= bus.act_rd_en ? act_mem[bus.act_addr] : '0;
        bus.wgt_data <= bus.wgt_rd_en ? wgt_mem[bus.wgt_addr] : '0;
    end

    // Behavioural MAC.
    assign prod = bus.mac_A * bus.mac_B;
    always @(posedge clk) begin
        if (bus.mac_clr) acc <= '0;
        else if (bus.mac_en) acc <= acc + {{2{prod[2*I_W-1]}}, prod};
        if (bus.mac_en_out) bus.mac_Y <= acc;
    end

    task automatic chk(input string tag, input logic signed [RES_W-1:0] obs,
                       input logic signed [RES_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample_cycle();
        if (bus.act_rd_en) act_q.push_back(int'(bus.act_addr));
        if (bus.wgt_rd_en) wgt_q.push_back(int'(bus.wgt_addr));
        en_cnt  += int'(bus.mac_en);
        clr_cnt += int'(bus.mac_clr);
        eo_cnt  += int'(bus.mac_en_out);
        if ((int'(bus.mac_clr) + int'(bus.mac_en) + int'(bus.mac_en_out)) > 1) ohv_cnt++;
        if (!bus.busy) busy_low++;
    endtask

    // Runs one dot product, checks it, holds the result hold cycles, then accepts it.
    task automatic do_op(input int n, input int ab, input int wb, input int hold,
                         input bit spam, input string tag);
        logic signed [RES_W-1:0] exp_res;
        logic signed [RES_W-1:0] a66, b66;
        logic signed [RES_W-1:0] res0;
        int cyc, vcyc, bad, unstable;
        exp_res = '0;
        for (int k = 0; k < n; k++) begin
            a66 = act_mem[(ab + k) % DEPTH];
            b66 = wgt_mem[(wb + k) % DEPTH];
            exp_res = exp_res + a66 * b66;
        end
        en_cnt = 0; clr_cnt = 0; eo_cnt = 0; ohv_cnt = 0; busy_low = 0;
        act_q.delete(); wgt_q.delete();
        bus.vec_len  = LEN_W'(n);
        bus.act_base = ADDR_W'(ab);
        bus.wgt_base = ADDR_W'(wb);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; vcyc = 0;
        while (vcyc == 0 && cyc <= n + 20) begin
            sample_cycle();
            if (bus.res_valid) vcyc = cyc;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk({tag, "_valid_cycle"}, vcyc, (n == 0) ? 4 : n + 5);
        chk({tag, "_res"}, bus.res_data, exp_res);
        chk({tag, "_en_cnt"}, en_cnt, n);
        chk({tag, "_clr_cnt"}, clr_cnt, 1);
        chk({tag, "_enout_cnt"}, eo_cnt, 1);
        chk({tag, "_onehot_viol"}, ohv_cnt, 0);
        chk({tag, "_busy_low"}, busy_low, 0);
        chk({tag, "_addr_cnt"}, act_q.size() + wgt_q.size(), 2 * n);
        bad = 0;
        for (int k = 0; k < act_q.size() && k < wgt_q.size(); k++) begin
            if (act_q[k] != (ab + k) % DEPTH) bad++;
            if (wgt_q[k] != (wb + k) % DEPTH) bad++;
        end
        chk({tag, "_addr_bad"}, bad, 0);
        res0 = bus.res_data;
        unstable = 0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.start   = spam && (i % 3 == 0);
            bus.vec_len = LEN_W'($urandom_range(1, 5));
            @(posedge clk); #1;
            if (bus.res_valid !== 1'b1 || bus.res_data !== res0 || bus.busy !== 1'b1
                || bus.mac_clr !== 1'b0) unstable++;
        end
        if (hold > 0) chk({tag, "_hold_unstable"}, unstable, 0);
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk({tag, "_valid_after_accept"}, bus.res_valid, 0);
        chk({tag, "_busy_after_accept"}, bus.busy, 0);
        if (spam) begin
            unstable = 0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                if (bus.busy !== 1'b0 || bus.mac_clr !== 1'b0) unstable++;
            end
            chk({tag, "_idle_after_spam"}, unstable, 0);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ctrl"}, {bus.act_rd_en, bus.wgt_rd_en, bus.mac_clr, bus.mac_en,
                             bus.mac_en_out, bus.res_valid, bus.busy}, 0);
        chk({tag, "_addr"}, {bus.act_addr, bus.wgt_addr}, 0);
        chk({tag, "_data"}, bus.res_data, 0);
    endtask

    initial begin
        int n, ab, wb;
        tests = 0; fails = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.vec_len = '0; bus.act_base = '0; bus.wgt_base = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            act_mem[i] = '0;
            wgt_mem[i] = '0;
        end
        #12;
        chk_outs_zero("reset");
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // N=4 basic
        for (int k = 0; k < 4; k++) begin
            act_mem[10 + k] = I_W'(k + 1);
            wgt_mem[200 + k] = I_W'(k + 5);
        end
        do_op(4, 10, 200, 0, 1'b0, "n4");

        // N=3 signed
        act_mem[300] = -32'sd3; act_mem[301] = 32'sd7;  act_mem[302] = -32'sd20;
        wgt_mem[400] = 32'sd19; wgt_mem[401] = -32'sd5; wgt_mem[402] = 32'sd2;
        do_op(3, 300, 400, 0, 1'b0, "n3_signed");

        // N=0 after a nonzero result
        do_op(0, 5, 6, 0, 1'b0, "n0");

        // Address wrap
        for (int k = 0; k < 4; k++) begin
            act_mem[(1022 + k) % DEPTH] = I_W'(k + 2);
            wgt_mem[500 + k] = I_W'(3 - k);
        end
        do_op(4, 1022, 500, 0, 1'b0, "wrap");
        chk("wrap_addr2", (act_q.size() > 2) ? act_q[2] : -1, 0);

        // Backpressure with ignored start pulses
        do_op(3, 300, 400, 20, 1'b1, "hold20");

        // Random vectors with full-range signed data
        for (int t = 0; t < 6; t++) begin
            n  = $urandom_range(0, 12);
            ab = $urandom_range(0, DEPTH - 1);
            wb = $urandom_range(0, DEPTH - 1);
            for (int k = 0; k < n; k++) begin
                act_mem[(ab + k) % DEPTH] = I_W'($urandom);
                wgt_mem[(wb + k) % DEPTH] = I_W'($urandom);
            end
            do_op(n, ab, wb, $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", t));
        end

        // Reset mid-STREAM at k=2
        bus.vec_len = LEN_W'(6); bus.act_base = ADDR_W'(40); bus.wgt_base = ADDR_W'(80);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midstream_addr", {bus.act_rd_en, bus.act_addr}, {1'b1, ADDR_W'(42)});
        rst = 1'b0;
        #1;
        chk_outs_zero("midstream_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_outs_zero("post_rst_idle");
        act_mem[700] = 32'sd1; act_mem[701] = 32'sd1;
        wgt_mem[800] = 32'sd2; wgt_mem[801] = 32'sd2;
        do_op(2, 700, 800, 0, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
